// File: rtl/cc_mem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cc_mem_load_ctrl
// Purpose  : Load controller between the control unit and main memory.
//            Accepts a load request in IDLE, issues a read and waits for the
//            memory read-data-valid strobe, then pulses Done with the
//            writeback select. A missing strobe aborts the read after
//            TIMEOUT_CYCLES wait cycles and pulses Error.
// Ports    : CC_MEM_LOAD_CTRL_CLOCK_50        - system clock (rising edge)
//            CC_MEM_LOAD_CTRL_RESET_InHigh    - async active-high reset
//            CC_MEM_LOAD_CTRL_Load_Req/_Addr  - load request and address
//            CC_MEM_LOAD_CTRL_Mem_Ack/_Data_InBUS - memory read response
//            CC_MEM_LOAD_CTRL_Mem_Rd_En/_Mem_Addr - memory read command
//            CC_MEM_LOAD_CTRL_Data_OutBUS     - last successfully loaded data
//            CC_MEM_LOAD_CTRL_RD              - writeback select (1 = memory)
//            CC_MEM_LOAD_CTRL_Busy/_Done/_Error - status
// Revision : 1.0 - initial release
// ============================================================================
module cc_mem_load_ctrl #(
    parameter int DATAWIDTH_BUS  = 32,
    parameter int ADDRWIDTH_BUS  = 12,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                     CC_MEM_LOAD_CTRL_CLOCK_50,
    input  logic                     CC_MEM_LOAD_CTRL_RESET_InHigh,
    input  logic                     CC_MEM_LOAD_CTRL_Load_Req,
    input  logic [ADDRWIDTH_BUS-1:0] CC_MEM_LOAD_CTRL_Load_Addr,
    input  logic                     CC_MEM_LOAD_CTRL_Mem_Ack,
    input  logic [DATAWIDTH_BUS-1:0] CC_MEM_LOAD_CTRL_Mem_Data_InBUS,
    output logic                     CC_MEM_LOAD_CTRL_Mem_Rd_En,
    output logic [ADDRWIDTH_BUS-1:0] CC_MEM_LOAD_CTRL_Mem_Addr,
    output logic [DATAWIDTH_BUS-1:0] CC_MEM_LOAD_CTRL_Data_OutBUS,
    output logic                     CC_MEM_LOAD_CTRL_RD,
    output logic                     CC_MEM_LOAD_CTRL_Busy,
    output logic                     CC_MEM_LOAD_CTRL_Done,
    output logic                     CC_MEM_LOAD_CTRL_Error
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;
    localparam logic [1:0] c_ERR  = 2'd3;

    // Last counter value still spent waiting; reaching it without an ack aborts.
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]               r_state;
    logic [1:0]               w_state_next;
    logic [7:0]               r_cnt;
    logic [ADDRWIDTH_BUS-1:0] r_mem_addr;
    logic [DATAWIDTH_BUS-1:0] r_data;

    logic w_rd_en;
    logic w_rd;
    logic w_busy;
    logic w_done;
    logic w_error;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CC_MEM_LOAD_CTRL_CLOCK_50 or posedge CC_MEM_LOAD_CTRL_RESET_InHigh) begin
        if (CC_MEM_LOAD_CTRL_RESET_InHigh) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. An ack wins over the timeout on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (CC_MEM_LOAD_CTRL_Load_Req) begin
                    w_state_next = c_WAIT;
                end
            end
            c_WAIT: begin
                if (CC_MEM_LOAD_CTRL_Mem_Ack) begin
                    w_state_next = c_DONE;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    w_state_next = c_ERR;
                end
            end
            c_DONE:  w_state_next = c_IDLE;
            c_ERR:   w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: state only, so no input-to-output paths exist.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_en = 1'b0;
        w_rd    = 1'b0;
        w_busy  = 1'b1;
        w_done  = 1'b0;
        w_error = 1'b0;
        case (r_state)
            c_IDLE:  w_busy  = 1'b0;
            c_WAIT:  w_rd_en = 1'b1;
            c_DONE: begin
                w_done = 1'b1;
                w_rd   = 1'b1;
            end
            c_ERR:   w_error = 1'b1;
            default: w_busy  = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: address capture, timeout counter, load data register
    // ------------------------------------------------------------------
    always_ff @(posedge CC_MEM_LOAD_CTRL_CLOCK_50 or posedge CC_MEM_LOAD_CTRL_RESET_InHigh) begin
        if (CC_MEM_LOAD_CTRL_RESET_InHigh) begin
            r_cnt      <= 8'd0;
            r_mem_addr <= '0;
            r_data     <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (CC_MEM_LOAD_CTRL_Load_Req) begin
                        r_mem_addr <= CC_MEM_LOAD_CTRL_Load_Addr;
                        r_cnt      <= 8'd0;
                    end
                end
                c_WAIT: begin
                    if (CC_MEM_LOAD_CTRL_Mem_Ack) begin
                        r_data <= CC_MEM_LOAD_CTRL_Mem_Data_InBUS;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign CC_MEM_LOAD_CTRL_Mem_Rd_En   = w_rd_en;
    assign CC_MEM_LOAD_CTRL_Mem_Addr    = r_mem_addr;
    assign CC_MEM_LOAD_CTRL_Data_OutBUS = r_data;
    assign CC_MEM_LOAD_CTRL_RD          = w_rd;
    assign CC_MEM_LOAD_CTRL_Busy        = w_busy;
    assign CC_MEM_LOAD_CTRL_Done        = w_done;
    assign CC_MEM_LOAD_CTRL_Error       = w_error;

endmodule
`default_nettype wire

// File: tb/tb_cc_mem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cc_mem_load_ctrl
// Purpose  : Directed self-checking bench for cc_mem_load_ctrl. Inputs are
//            driven and outputs sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cc_mem_load_ctrl;

    logic        clk;
    logic        rst;
    logic        load_req;
    logic [11:0] load_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        mem_rd_en;
    logic [11:0] mem_addr;
    logic [31:0] data_out;
    logic        rd;
    logic        busy;
    logic        done;
    logic        error;

    int n_total = 0;
    int n_pass  = 0;

    cc_mem_load_ctrl #(
        .DATAWIDTH_BUS (32),
        .ADDRWIDTH_BUS (12),
        .TIMEOUT_CYCLES(15)
    ) u_dut (
        .CC_MEM_LOAD_CTRL_CLOCK_50       (clk),
        .CC_MEM_LOAD_CTRL_RESET_InHigh   (rst),
        .CC_MEM_LOAD_CTRL_Load_Req       (load_req),
        .CC_MEM_LOAD_CTRL_Load_Addr      (load_addr),
        .CC_MEM_LOAD_CTRL_Mem_Ack        (mem_ack),
        .CC_MEM_LOAD_CTRL_Mem_Data_InBUS (mem_data),
        .CC_MEM_LOAD_CTRL_Mem_Rd_En      (mem_rd_en),
        .CC_MEM_LOAD_CTRL_Mem_Addr       (mem_addr),
        .CC_MEM_LOAD_CTRL_Data_OutBUS    (data_out),
        .CC_MEM_LOAD_CTRL_RD             (rd),
        .CC_MEM_LOAD_CTRL_Busy           (busy),
        .CC_MEM_LOAD_CTRL_Done           (done),
        .CC_MEM_LOAD_CTRL_Error          (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Bundle of all status outputs: {rd_en, rd, busy, done, error}
    function automatic logic [31:0] status();
        return {27'd0, mem_rd_en, rd, busy, done, error};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [8:0]  rd_vec;
        logic [8:0]  done_vec;

        rst       = 1'b1;
        load_req  = 1'b0;
        load_addr = 12'h000;
        mem_ack   = 1'b0;
        mem_data  = 32'h0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("reset_status", status(), 32'h0);
        check("reset_addr", {20'd0, mem_addr}, 32'h0);
        check("reset_data", data_out, 32'h0);

        // ---------------- basic load, request on first edge after reset ----
        rst       = 1'b0;
        load_req  = 1'b1;
        load_addr = 12'h0A4;
        @(negedge clk);
        load_req  = 1'b0;
        load_addr = 12'h555;
        check("t1_wait1_status", status(), 32'h14);   // rd_en, busy
        check("t1_addr", {20'd0, mem_addr}, 32'h0A4);
        @(negedge clk);
        check("t1_wait2_status", status(), 32'h14);
        check("t1_addr_stable", {20'd0, mem_addr}, 32'h0A4);
        mem_ack  = 1'b1;
        mem_data = 32'hDEADBEEF;
        @(negedge clk);
        mem_ack  = 1'b0;
        mem_data = 32'h0;
        check("t1_done_status", status(), 32'h0E);    // rd, busy, done
        check("t1_data", data_out, 32'hDEADBEEF);
        @(negedge clk);
        check("t1_idle_status", status(), 32'h0);
        check("t1_data_hold", data_out, 32'hDEADBEEF);

        // ---------------- timeout ----------------
        load_req  = 1'b1;
        load_addr = 12'h123;
        @(negedge clk);
        load_req = 1'b0;
        n = 0;
        while (mem_rd_en && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("t2_rd_en_cycles", n, 32'd15);
        check("t2_err_status", status(), 32'h05);     // busy, error
        check("t2_data_kept", data_out, 32'hDEADBEEF);
        @(negedge clk);
        check("t2_idle_status", status(), 32'h0);

        // ---------------- ack coincident with timeout ----------------
        load_req  = 1'b1;
        load_addr = 12'h7FE;
        @(negedge clk);
        load_req = 1'b0;
        repeat (14) @(negedge clk);
        check("t3_still_wait", status(), 32'h14);
        mem_ack  = 1'b1;
        mem_data = 32'h12345678;
        @(negedge clk);
        mem_ack  = 1'b0;
        check("t3_done_status", status(), 32'h0E);
        check("t3_data", data_out, 32'h12345678);
        @(negedge clk);
        check("t3_no_error", status(), 32'h0);

        // ---------------- back-to-back requests ----------------
        load_req  = 1'b1;
        load_addr = 12'h321;
        mem_ack   = 1'b1;
        mem_data  = 32'hA5A5A5A5;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rd_vec[i]   = mem_rd_en;
            done_vec[i] = done;
        end
        load_req = 1'b0;
        mem_ack  = 1'b0;
        check("t4_rd_en_pattern", {23'd0, rd_vec}, 32'b001001001);
        check("t4_done_pattern", {23'd0, done_vec}, 32'b010010010);
        check("t4_data", data_out, 32'hA5A5A5A5);
        check("t4_addr", {20'd0, mem_addr}, 32'h321);
        @(negedge clk);

        // ---------------- reset mid-WAIT ----------------
        load_req  = 1'b1;
        load_addr = 12'h0F0;
        @(negedge clk);
        load_req = 1'b0;
        check("t5_in_wait", status(), 32'h14);
        #2 rst = 1'b1;
        #1;
        check("t5_async_status", status(), 32'h0);
        check("t5_async_addr", {20'd0, mem_addr}, 32'h0);
        check("t5_async_data", data_out, 32'h0);
        @(negedge clk);
        rst      = 1'b0;
        mem_ack  = 1'b1;
        mem_data = 32'hCAFEF00D;
        @(negedge clk);
        check("t5_ack_ignored", status(), 32'h0);
        @(negedge clk);
        mem_ack = 1'b0;
        check("t5_still_idle", status(), 32'h0);
        check("t5_data_zero", data_out, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cc_mem_load_ctrl.md
CC_MEM_LOAD_CTRL -- requirements
Module: cc_mem_load_ctrl

Interface
REQ-001 Parameter DATAWIDTH_BUS, default 32, SHALL set the data bus width.
REQ-002 Parameter ADDRWIDTH_BUS, default 12, SHALL set the memory address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 15, range 2..255, SHALL set the maximum WAIT cycles before a read aborts.
REQ-004 CC_MEM_LOAD_CTRL_CLOCK_50  in  1  single system clock; all state updates on its rising edge.
REQ-005 CC_MEM_LOAD_CTRL_RESET_InHigh  in  1  reset, asynchronous, active-high.
REQ-006 CC_MEM_LOAD_CTRL_Load_Req  in  1  load request from control unit, sampled only in IDLE.
REQ-007 CC_MEM_LOAD_CTRL_Load_Addr  in  ADDRWIDTH_BUS  load address, captured with Load_Req.
REQ-008 CC_MEM_LOAD_CTRL_Mem_Ack  in  1  main memory read-data-valid strobe.
REQ-009 CC_MEM_LOAD_CTRL_Mem_Data_InBUS  in  DATAWIDTH_BUS  main memory read data, valid when Mem_Ack=1.
REQ-010 CC_MEM_LOAD_CTRL_Mem_Rd_En  out  1  read enable to main memory.
REQ-011 CC_MEM_LOAD_CTRL_Mem_Addr  out  ADDRWIDTH_BUS  registered address to main memory.
REQ-012 CC_MEM_LOAD_CTRL_Data_OutBUS  out  DATAWIDTH_BUS  registered load data; feeds the main-memory input of the writeback bus mux.
REQ-013 CC_MEM_LOAD_CTRL_RD  out  1  writeback mux select; 1 = take memory data, 0 = take ALU result.
REQ-014 CC_MEM_LOAD_CTRL_Busy  out  1  high whenever state is not IDLE.
REQ-015 CC_MEM_LOAD_CTRL_Done  out  1  one-cycle pulse: load completed.
REQ-016 CC_MEM_LOAD_CTRL_Error  out  1  one-cycle pulse: load timed out.

Function
REQ-017 FSM SHALL have states IDLE, WAIT, DONE, ERR; all outputs SHALL be registered or decoded from state only (no input-to-output combinational path).
REQ-018 IDLE: Load_Req=1 at a rising edge SHALL capture Load_Addr into Mem_Addr, clear the timeout counter, and enter WAIT.
REQ-019 IDLE with Load_Req=0 SHALL remain IDLE; Mem_Ack in IDLE SHALL be ignored.
REQ-020 WAIT: Mem_Rd_En SHALL be 1 for every WAIT cycle and 0 in all other states; Mem_Addr SHALL stay stable.
REQ-021 WAIT: Mem_Ack=1 at an edge SHALL load Mem_Data_InBUS into Data_OutBUS and enter DONE.
REQ-022 WAIT: the 8-bit timeout counter SHALL increment each cycle without Mem_Ack; when it equals TIMEOUT_CYCLES-1 without Mem_Ack the FSM SHALL enter ERR.
REQ-023 Mem_Ack on the same edge as the timeout condition SHALL take priority: DONE, not ERR.
REQ-024 DONE: Done=1 and RD=1 for exactly one cycle, then IDLE unconditionally.
REQ-025 ERR: Error=1 for exactly one cycle, RD=0, Data_OutBUS unchanged, then IDLE unconditionally.
REQ-026 Load_Req in WAIT, DONE or ERR SHALL be ignored (not queued).
REQ-027 Data_OutBUS SHALL hold its last captured value until the next successful load.
REQ-028 Latency: Load_Req sampled at edge N, Mem_Ack sampled at edge N+k (k>=1) -> Done/RD/new Data_OutBUS visible after edge N+k, cleared after edge N+k+1.
REQ-029 Minimum request-to-request interval SHALL be 3 cycles (IDLE, WAIT, DONE/ERR).

Reset
REQ-030 RESET_InHigh=1 SHALL immediately, independent of clock, force state IDLE, counter 0, Mem_Addr 0, Data_OutBUS 0, and Mem_Rd_En, RD, Busy, Done, Error to 0.
REQ-031 Reset asserted during WAIT SHALL abort the read with no Done or Error pulse; a Mem_Ack arriving after reset release SHALL be ignored.
REQ-032 First Load_Req SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-033 Reset, then Load_Req=1 Addr=0x0A4, Mem_Ack with Data=0xDEADBEEF 2 cycles later -> Mem_Rd_En high 2 cycles, Mem_Addr=0x0A4, Done=RD=1 one cycle, Data_OutBUS=0xDEADBEEF.
REQ-034 Load_Req, Mem_Ack never asserted, TIMEOUT_CYCLES=15 -> Mem_Rd_En high 15 cycles, Error=1 one cycle, RD=0, Data_OutBUS keeps previous value 0xDEADBEEF.
REQ-035 Mem_Ack with Data=0x12345678 on the same edge the counter reaches 14 -> Done=1, Error stays 0, Data_OutBUS=0x12345678.
REQ-036 Load_Req held high continuously with Mem_Ack one cycle after each request -> one load accepted every 3 cycles; Load_Req during WAIT/DONE has no effect.
REQ-037 Reset pulsed mid-WAIT, then Mem_Ack=1 with Data=0xCAFEF00D -> all outputs 0 asynchronously, no Done/Error, Data_OutBUS stays 0x00000000.
